// File: rtl/uart_rx.sv
// 8E1 UART receiver with oversampled bit timing, 2-flop input synchronizer,
// break handling and a small receive FIFO with a registered head byte.
module uart_rx #(
    parameter int OVERSAMPLE = 16,
    parameter int FIFO_DEPTH = 4
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       rx,
    input  logic       ready,
    output logic [7:0] data,
    output logic       valid,
    output logic       parity_err,
    output logic       frame_err,
    output logic       overrun,
    output logic       busy
);

    localparam int CW   = $clog2(OVERSAMPLE);
    localparam int AW   = $clog2(FIFO_DEPTH);
    localparam int CNTW = AW + 1;
    localparam logic [CW-1:0]   CNT_LAST = CW'(OVERSAMPLE - 1);
    localparam logic [CW-1:0]   CNT_MID  = CW'(OVERSAMPLE / 2 - 1);
    localparam logic [CNTW-1:0] CNT_FULL = CNTW'(FIFO_DEPTH);

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_START  = 3'd1,
        ST_DATA   = 3'd2,
        ST_PARITY = 3'd3,
        ST_STOP   = 3'd4,
        ST_BREAK  = 3'd5
    } state_t;

    // Even parity: data bits plus parity bit must XOR to zero.
    function automatic logic parity_mismatch(input logic [7:0] d, input logic p);
        return ^{d, p};
    endfunction

    logic            rx_meta_r;
    logic            rxs_r;
    state_t          state_r;
    state_t          state_next_s;
    logic [CW-1:0]   cnt_r;
    logic [CW-1:0]   cnt_next_s;
    logic [2:0]      idx_r;
    logic [2:0]      idx_next_s;
    logic [7:0]      shift_r;
    logic [7:0]      shift_next_s;
    logic            par_bit_r;
    logic            par_bit_next_s;
    logic            push_s;
    logic            perr_s;
    logic            ferr_s;

    logic [7:0]      mem_r [FIFO_DEPTH];
    logic [AW-1:0]   wr_ptr_r;
    logic [AW-1:0]   rd_ptr_r;
    logic [CNTW-1:0] count_r;
    logic [CNTW-1:0] count_next_s;
    logic            full_s;
    logic            pop_s;
    logic            do_push_s;
    logic            ovr_s;
    logic [7:0]      data_next_s;

    logic [7:0]      data_r;
    logic            valid_r;
    logic            parity_err_r;
    logic            frame_err_r;
    logic            overrun_r;
    logic            busy_r;

    // Receiver next-state, bit sampling and frame verdict.
    always_comb begin
        state_next_s   = state_r;
        cnt_next_s     = (cnt_r == CNT_LAST) ? '0 : cnt_r + CW'(1);
        idx_next_s     = idx_r;
        shift_next_s   = shift_r;
        par_bit_next_s = par_bit_r;
        push_s         = 1'b0;
        perr_s         = 1'b0;
        ferr_s         = 1'b0;
        case (state_r)
            ST_IDLE: begin
                cnt_next_s = '0;
                if (!rxs_r) begin
                    state_next_s = ST_START;
                end else begin
                    state_next_s = ST_IDLE;
                end
            end
            ST_START: begin
                if (cnt_r == CNT_MID) begin
                    cnt_next_s = '0;
                    idx_next_s = 3'd0;
                    state_next_s = rxs_r ? ST_IDLE : ST_DATA;
                end else begin
                    state_next_s = ST_START;
                end
            end
            ST_DATA: begin
                if (cnt_r == CNT_LAST) begin
                    shift_next_s[idx_r] = rxs_r;
                    if (idx_r == 3'd7) begin
                        state_next_s = ST_PARITY;
                    end else begin
                        idx_next_s = idx_r + 3'd1;
                    end
                end else begin
                    state_next_s = ST_DATA;
                end
            end
            ST_PARITY: begin
                if (cnt_r == CNT_LAST) begin
                    par_bit_next_s = rxs_r;
                    state_next_s   = ST_STOP;
                end else begin
                    state_next_s = ST_PARITY;
                end
            end
            ST_STOP: begin
                // Leaving at mid stop bit lets the next start edge be caught without a gap.
                if (cnt_r == CNT_LAST) begin
                    if (!rxs_r) begin
                        ferr_s       = 1'b1;
                        state_next_s = ST_BREAK;
                    end else if (parity_mismatch(shift_r, par_bit_r)) begin
                        perr_s       = 1'b1;
                        state_next_s = ST_IDLE;
                    end else begin
                        push_s       = 1'b1;
                        state_next_s = ST_IDLE;
                    end
                end else begin
                    state_next_s = ST_STOP;
                end
            end
            ST_BREAK: begin
                cnt_next_s = '0;
                if (rxs_r) begin
                    state_next_s = ST_IDLE;
                end else begin
                    state_next_s = ST_BREAK;
                end
            end
            default: begin
                state_next_s = ST_IDLE;
                cnt_next_s   = '0;
            end
        endcase
    end

    // FIFO control and next head byte.
    always_comb begin
        full_s      = (count_r == CNT_FULL);
        pop_s       = valid_r & ready;
        do_push_s   = push_s & (~full_s | pop_s);
        ovr_s       = push_s & full_s & ~pop_s;
        data_next_s = data_r;
        case ({do_push_s, pop_s})
            2'b10:   count_next_s = count_r + CNTW'(1);
            2'b01:   count_next_s = count_r - CNTW'(1);
            default: count_next_s = count_r;
        endcase
        if (pop_s) begin
            if (count_r > CNTW'(1)) begin
                data_next_s = mem_r[rd_ptr_r + AW'(1)];
            end else if (do_push_s) begin
                data_next_s = shift_r;
            end else begin
                data_next_s = data_r;
            end
        end else if (do_push_s && (count_r == '0)) begin
            data_next_s = shift_r;
        end else begin
            data_next_s = data_r;
        end
    end

    // Synchronizer, receiver state and FIFO storage.
    always_ff @(posedge clk) begin
        if (rst) begin
            rx_meta_r    <= 1'b1;
            rxs_r        <= 1'b1;
            state_r      <= ST_IDLE;
            cnt_r        <= '0;
            idx_r        <= 3'd0;
            shift_r      <= 8'h00;
            par_bit_r    <= 1'b0;
            wr_ptr_r     <= '0;
            rd_ptr_r     <= '0;
            count_r      <= '0;
            data_r       <= 8'h00;
            valid_r      <= 1'b0;
            parity_err_r <= 1'b0;
            frame_err_r  <= 1'b0;
            overrun_r    <= 1'b0;
            busy_r       <= 1'b0;
            for (int i = 0; i < FIFO_DEPTH; i++) begin
                mem_r[i] <= 8'h00;
            end
        end else begin
            rx_meta_r    <= rx;
            rxs_r        <= rx_meta_r;
            state_r      <= state_next_s;
            cnt_r        <= cnt_next_s;
            idx_r        <= idx_next_s;
            shift_r      <= shift_next_s;
            par_bit_r    <= par_bit_next_s;
            count_r      <= count_next_s;
            data_r       <= data_next_s;
            valid_r      <= (count_next_s != '0);
            parity_err_r <= perr_s;
            frame_err_r  <= ferr_s;
            overrun_r    <= ovr_s;
            busy_r       <= (state_next_s != ST_IDLE);
            if (do_push_s) begin
                mem_r[wr_ptr_r] <= shift_r;
                wr_ptr_r        <= wr_ptr_r + AW'(1);
            end
            if (pop_s) begin
                rd_ptr_r <= rd_ptr_r + AW'(1);
            end
        end
    end

    assign data       = data_r;
    assign valid      = valid_r;
    assign parity_err = parity_err_r;
    assign frame_err  = frame_err_r;
    assign overrun    = overrun_r;
    assign busy       = busy_r;

endmodule

// File: tb/tb_uart_rx.sv
// Scoreboard bench for uart_rx: frames are generated at bit level, a frame-level
// model predicts bytes and error pulses, and a negedge monitor checks the DUT.
module tb_uart_rx;

    localparam int OS = 16;
    localparam int K_PAR = 1;
    localparam int K_FRM = 2;
    localparam int K_OVR = 3;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       rx = 1'b1;
    logic       ready = 1'b1;
    logic [7:0] data;
    logic       valid;
    logic       parity_err;
    logic       frame_err;
    logic       overrun;
    logic       busy;

    int n_vec = 0;
    int n_err = 0;
    int model_occ = 0;
    logic [7:0] exp_data_q [$];
    int         exp_err_q  [$];

    uart_rx #(.OVERSAMPLE(OS), .FIFO_DEPTH(4)) dut (
        .clk(clk), .rst(rst), .rx(rx), .ready(ready), .data(data), .valid(valid),
        .parity_err(parity_err), .frame_err(frame_err), .overrun(overrun), .busy(busy)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic send_bit(input logic b);
        rx = b;
        tick(OS);
    endtask

    // Frame-level expectation, then the serial waveform.
    task automatic send_frame(input logic [7:0] d, input bit pflip, input bit stop_b, input int hold_low);
        if (!stop_b) begin
            exp_err_q.push_back(K_FRM);
        end else if (pflip) begin
            exp_err_q.push_back(K_PAR);
        end else if (!ready && model_occ == 4) begin
            exp_err_q.push_back(K_OVR);
        end else begin
            exp_data_q.push_back(d);
            if (!ready) model_occ++;
        end
        send_bit(1'b0);
        for (int i = 0; i < 8; i++) send_bit(d[i]);
        send_bit((^d) ^ pflip);
        send_bit(stop_b);
        if (!stop_b) begin
            rx = 1'b0;
            tick(hold_low);
            chk("break_busy", busy, 1);
            chk("break_no_valid", valid, 0);
            rx = 1'b1;
            tick(OS);
            chk("break_exit_busy", busy, 0);
        end else begin
            chk("stop_idle_busy", busy, 0);
        end
    endtask

    // Monitor: pops the scoreboard whenever the DUT presents a byte or a pulse.
    initial begin
        int kind;
        forever begin
            @(negedge clk);
            if (!rst) begin
                if ((32'(parity_err) + 32'(frame_err) + 32'(overrun)) > 1) begin
                    chk("pulse_exclusive", {29'd0, parity_err, frame_err, overrun}, 0);
                end
                kind = parity_err ? K_PAR : frame_err ? K_FRM : overrun ? K_OVR : 0;
                if (kind != 0) begin
                    if (exp_err_q.size() == 0) chk("unexpected_pulse", kind, 0);
                    else chk("pulse_kind", kind, exp_err_q.pop_front());
                end
                if (valid && ready) begin
                    if (exp_data_q.size() == 0) chk("unexpected_byte", {24'd0, data}, 32'hFFFF_FFFF);
                    else chk("rx_byte", {24'd0, data}, {24'd0, exp_data_q.pop_front()});
                end
            end
        end
    end

    initial begin
        #5_000_000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int waited;
        tick(3);
        chk("rst_valid", valid, 0);
        chk("rst_data", data, 8'h00);
        chk("rst_busy", busy, 0);
        chk("rst_pulses", {parity_err, frame_err, overrun}, 3'b000);
        rst = 1'b0;
        tick(20);

        // Basic good frame, parity error then recovery, framing error/break then recovery.
        send_frame(8'h48, 1'b0, 1'b1, 0);
        tick(10);
        send_frame(8'h48, 1'b1, 1'b1, 0);
        send_frame(8'h55, 1'b0, 1'b1, 0);
        tick(10);
        send_frame(8'h41, 1'b0, 1'b0, 40 - OS);
        send_frame(8'h42, 1'b0, 1'b1, 0);
        tick(10);

        // Start-bit glitch.
        rx = 1'b0;
        tick(4);
        chk("glitch_busy", busy, 1);
        rx = 1'b1;
        tick(20);
        chk("glitch_idle", busy, 0);
        chk("glitch_no_valid", valid, 0);

        // Fill the FIFO with ready low; the fifth byte overruns.
        ready = 1'b0;
        model_occ = 0;
        for (int i = 1; i <= 5; i++) send_frame(8'(i), 1'b0, 1'b1, 0);
        tick(5);
        chk("full_valid", valid, 1);
        chk("full_head", data, 8'h01);
        ready = 1'b1;
        waited = 0;
        while (valid && waited < 20) begin
            tick(1);
            waited++;
        end
        chk("drain_empty", valid, 0);
        model_occ = 0;

        // Reset in the middle of the data bits.
        send_bit(1'b0);
        send_bit(1'b0);
        send_bit(1'b1);
        send_bit(1'b1);
        rst = 1'b1;
        rx = 1'b1;
        tick(1);
        chk("midrst_valid", valid, 0);
        chk("midrst_data", data, 8'h00);
        chk("midrst_busy", busy, 0);
        chk("midrst_pulses", {parity_err, frame_err, overrun}, 3'b000);
        tick(1);
        rst = 1'b0;
        tick(30);
        chk("postrst_busy", busy, 0);
        send_frame(8'h33, 1'b0, 1'b1, 0);
        tick(5);

        // Randomized frames, including back-to-back ones.
        for (int n = 0; n < 40; n++) begin
            logic [7:0] d;
            bit pf;
            bit sb;
            d  = 8'($urandom_range(0, 255));
            pf = ($urandom_range(0, 3) == 0);
            sb = ($urandom_range(0, 7) != 0);
            send_frame(d, pf, sb, $urandom_range(0, 30));
            tick($urandom_range(0, 1) == 0 ? 0 : $urandom_range(1, 20));
        end
        tick(30);
        chk("leftover_bytes", exp_data_q.size(), 0);
        chk("leftover_pulses", exp_err_q.size(), 0);
        chk("final_valid", valid, 0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
